pc_fetch_stage: RTL and testbench
=================================

// Module: pc_fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the branch unit's Cur_PC input and consuming its PcSel/BrPC redirect.
//  Holds the program counter, selects the next PC (sequential or redirect) and presents the instruction memory address.
//  Registers the fetched instruction into the IF/ID pipeline register with a valid bit; inserts bubbles on redirect/stall.
//  Runs a halt/drain FSM so the core stops cleanly on an ECALL/EBREAK-style halt request.
// PARAMETERS
//  PC_W         9             PC width in bits (byte address); matches the branch unit's Cur_PC width
//  RESET_PC     0             PC value loaded on reset (PC_W bits, must be 4-byte aligned)
//  DRAIN_CYCLES 3             bubble cycles inserted after halt_req before entering HALTED (1..15)
//  NOP_INSTR    32'h00000013  instruction word driven on if_instr for a bubble (ADDI x0,x0,0)
// PORTS
//  clk           in   1     rising-edge clock
//  reset_n       in   1     asynchronous, active-low reset
//  stall         in   1     hazard stall from decode: hold PC and IF/ID
//  PcSel         in   1     redirect taken (from branch unit)
//  BrPC          in   32    redirect target (from branch unit)
//  halt_req      in   1     halt request (one-cycle pulse or level)
//  resume        in   1     leave HALTED state
//  imem_rdata    in   32    instruction word at imem_addr (combinational read)
//  imem_addr     out  PC_W  current PC to instruction memory
//  Cur_PC        out  PC_W  PC of the instruction in IF/ID (to branch unit via ID/EX)
//  if_instr      out  32    IF/ID instruction
//  if_valid      out  1     IF/ID holds a real instruction
//  halted        out  1     FSM is in HALTED
//  target_err    out  1     sticky: a redirect target was misaligned or out of PC range
//  redirect_cnt  out  32    taken redirects (see CONFIGURATION)
//  fetch_cnt     out  32    valid instructions registered into IF/ID (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, reset_n=0): PC=RESET_PC, Cur_PC=0, if_instr=NOP_INSTR, if_valid=0, halted=0,
//   target_err=0, counters=0, FSM=RUN. Reset asserted mid-operation overrides everything immediately.
//  imem_addr = PC (combinational from PC register). Fetch latency: instruction in IF/ID one cycle after PC.
//  Next-PC priority per cycle: (1) PcSel  (2) FSM not RUN or stall -> hold  (3) PC+4.
//   PC+4 is modulo 2^PC_W (wraps to 0 from 2^PC_W-4, no error).
//   Redirect: PC <= {BrPC[PC_W-1:2],2'b00}; if BrPC[1:0]!=0 or BrPC[31:PC_W]!=0, target_err<=1 (sticky until reset).
//   Redirect overrides stall; redirect in DRAIN/HALTED still updates PC but does not leave the state.
//  IF/ID update: PcSel -> bubble (if_valid=0, if_instr=NOP_INSTR, Cur_PC unchanged);
//   else stall in RUN -> hold all IF/ID; else RUN -> if_instr=imem_rdata, Cur_PC=PC, if_valid=1;
//   else (DRAIN/HALTED) -> bubble.
//  FSM states RUN, DRAIN, HALTED; 4-bit drain counter.
//   RUN: halt_req=1 -> DRAIN, counter=DRAIN_CYCLES-1 (halt_req outranks stall; PcSel same cycle still redirects).
//   DRAIN: counter decrements each cycle; at 0 -> HALTED. halt_req re-asserted is ignored.
//   HALTED: halted=1; resume=1 -> RUN, fetch restarts next cycle from held PC. resume outside HALTED ignored.
//   halt_req and resume both high in HALTED: resume wins.
// CONFIGURATION
//  PC_FETCH_STATS_EN defined: redirect_cnt +1 per cycle with PcSel=1; fetch_cnt +1 per cycle a valid
//   instruction is loaded into IF/ID; both saturate at 32'hFFFFFFFF; reset to 0.
//  Not defined: counters not built; redirect_cnt and fetch_cnt tied to 0. All other behaviour identical.
// TESTING
//  Reset release, RESET_PC=0, no stall -> imem_addr 0,4,8,..; if_valid=1 from 2nd cycle, Cur_PC lags imem_addr by 1.
//  PcSel=1, BrPC=0x40 at PC=0x10 with stall=1 -> next PC=0x40, IF/ID bubble (if_instr=0x00000013, if_valid=0).
//  BrPC=0x1002 (PC_W=9) -> PC=0x000, target_err=1 and stays 1 through later clean redirects.
//  PC=0x1FC, no stall -> next PC=0x000, target_err stays 0.
//  halt_req pulse, DRAIN_CYCLES=3 -> 3 bubble cycles, halted=1 on 4th; PC frozen; resume -> fetch continues at frozen PC.
//  With PC_FETCH_STATS_EN: 10 fetches + 2 redirects -> fetch_cnt=10, redirect_cnt=2; reset_n low mid-run -> all 0 at once.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: program counter, next-PC select, IF/ID pipeline register and halt/drain FSM.
// Define PC_FETCH_STATS_EN to build the saturating redirect_cnt / fetch_cnt counters.
module pc_fetch_stage #(
  parameter int unsigned      PC_W         = 9,
  parameter logic [PC_W-1:0]  RESET_PC     = '0,
  parameter int unsigned      DRAIN_CYCLES = 3,
  parameter logic [31:0]      NOP_INSTR    = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            halt_req,
  input  logic            resume,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] Cur_PC,
  output logic [31:0]     if_instr,
  output logic            if_valid,
  output logic            halted,
  output logic            target_err,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam logic [3:0]  DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  // Bits of BrPC above the PC range; all-zero mask when the PC spans the full word.
  localparam logic [31:0] RANGE_MASK = (PC_W >= 32) ? 32'h0 : ~((32'h1 << PC_W) - 32'h1);

  state_t          state, state_nxt;
  logic [3:0]      drain_cnt, drain_cnt_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            running;
  logic            load_fetch;
  logic            hold_ifid;
  logic            target_bad;

  assign running    = (state == ST_RUN);
  assign load_fetch = !PcSel && running && !stall;
  assign hold_ifid  = !PcSel && running && stall;
  assign target_bad = (|BrPC[1:0]) || (|(BrPC & RANGE_MASK));

  assign imem_addr  = pc;
  assign halted     = (state == ST_HALTED);

  always_comb begin
    pc_nxt = pc;
    if (PcSel) begin
      pc_nxt = {BrPC[PC_W-1:2], 2'b00};
    end else if (running && !stall) begin
      pc_nxt = pc + PC_W'(4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      target_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (PcSel && target_bad) begin
        target_err <= 1'b1;
      end
    end
  end

  // A redirect always squashes IF/ID; outside RUN the register only ever sees bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Cur_PC   <= '0;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (load_fetch) begin
      Cur_PC   <= pc;
      if_instr <= imem_rdata;
      if_valid <= 1'b1;
    end else if (!hold_ifid) begin
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      ST_RUN: begin
        if (halt_req) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == 4'd0) begin
          state_nxt = ST_HALTED;
        end else begin
          drain_cnt_nxt = drain_cnt - 4'd1;
        end
      end
      ST_HALTED: begin
        if (resume) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

`ifdef PC_FETCH_STATS_EN
  logic [31:0] redirect_q;
  logic [31:0] fetch_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_q <= '0;
      fetch_q    <= '0;
    end else begin
      if (PcSel && (redirect_q != 32'hFFFF_FFFF)) begin
        redirect_q <= redirect_q + 32'd1;
      end
      if (load_fetch && (fetch_q != 32'hFFFF_FFFF)) begin
        fetch_q <= fetch_q + 32'd1;
      end
    end
  end

  assign redirect_cnt = redirect_q;
  assign fetch_cnt    = fetch_q;
`else
  assign redirect_cnt = '0;
  assign fetch_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios then random stimulus against a behavioural model.
module tb_pc_fetch_stage;

  localparam int          PC_W    = 9;
  localparam int          DRAIN   = 3;
  localparam int          PC_SPAN = 1 << PC_W;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            stall = 1'b0;
  logic            PcSel = 1'b0;
  logic [31:0]     BrPC = '0;
  logic            halt_req = 1'b0;
  logic            resume = 1'b0;
  logic [31:0]     imem_rdata;
  logic [PC_W-1:0] imem_addr;
  logic [PC_W-1:0] Cur_PC;
  logic [31:0]     if_instr;
  logic            if_valid;
  logic            halted;
  logic            target_err;
  logic [31:0]     redirect_cnt;
  logic [31:0]     fetch_cnt;

  int vectors = 0;
  int miscompares = 0;

  int          m_pc;
  int          m_cur;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_halted;
  int          m_drain_left;
  bit          m_err;
  longint      m_redirects;
  longint      m_fetches;

  pc_fetch_stage #(
    .PC_W(PC_W),
    .RESET_PC('0),
    .DRAIN_CYCLES(DRAIN),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .PcSel(PcSel),
    .BrPC(BrPC),
    .halt_req(halt_req),
    .resume(resume),
    .imem_rdata(imem_rdata),
    .imem_addr(imem_addr),
    .Cur_PC(Cur_PC),
    .if_instr(if_instr),
    .if_valid(if_valid),
    .halted(halted),
    .target_err(target_err),
    .redirect_cnt(redirect_cnt),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Distinct instruction word per address, so a wrong fetch address shows up in if_instr.
  function automatic logic [31:0] mem_word(input int unsigned a);
    return (a * 32'd65537) ^ 32'hA500_0013;
  endfunction

  assign imem_rdata = mem_word(32'(imem_addr));

  function automatic logic [31:0] exp_count(input longint n);
`ifdef PC_FETCH_STATS_EN
    return 32'(n);
`else
    return (n >= 0) ? 32'h0 : 32'h0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc = 0;
    m_cur = 0;
    m_instr = NOP;
    m_valid = 0;
    m_halted = 0;
    m_drain_left = 0;
    m_err = 0;
    m_redirects = 0;
    m_fetches = 0;
  endtask

  // One clock of the reference behaviour, using the inputs that were present at the edge.
  task automatic modelStep(input bit st, input bit sel, input logic [31:0] br, input bit hr, input bit rs);
    bit running;
    running = !m_halted && (m_drain_left == 0);
    if (sel) begin
      m_valid = 0;
      m_instr = NOP;
    end else if (running && !st) begin
      m_instr = mem_word(m_pc);
      m_cur = m_pc;
      m_valid = 1;
      m_fetches++;
    end else if (!running) begin
      m_valid = 0;
      m_instr = NOP;
    end
    if (sel) begin
      m_pc = int'((br % PC_SPAN) / 4 * 4);
      if ((br % 4 != 0) || (br >= PC_SPAN)) m_err = 1;
      m_redirects++;
    end else if (running && !st) begin
      m_pc = (m_pc + 4) % PC_SPAN;
    end
    if (running) begin
      if (hr) m_drain_left = DRAIN;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (rs) begin
      m_halted = 0;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_pc));
    checkOutput({tag, ".Cur_PC"}, 32'(Cur_PC), 32'(m_cur));
    checkOutput({tag, ".if_instr"}, if_instr, m_instr);
    checkOutput({tag, ".if_valid"}, 32'(if_valid), 32'(m_valid));
    checkOutput({tag, ".halted"}, 32'(halted), 32'(m_halted));
    checkOutput({tag, ".target_err"}, 32'(target_err), 32'(m_err));
    checkOutput({tag, ".redirect_cnt"}, redirect_cnt, exp_count(m_redirects));
    checkOutput({tag, ".fetch_cnt"}, fetch_cnt, exp_count(m_fetches));
  endtask

  task automatic applyStimulus(input string tag, input bit st, input bit sel, input logic [31:0] br,
                               input bit hr, input bit rs);
    stall = st;
    PcSel = sel;
    BrPC = br;
    halt_req = hr;
    resume = rs;
    @(posedge clk);
    modelStep(st, sel, br, hr, rs);
    @(negedge clk);
    compareAll(tag);
  endtask

  // Asserts reset between edges and checks the outputs clear without waiting for a clock.
  task automatic asyncReset(input string tag);
    stall = 0;
    PcSel = 0;
    BrPC = '0;
    halt_req = 0;
    resume = 0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput({tag, ".rst_addr"}, 32'(imem_addr), 32'h0);
    checkOutput({tag, ".rst_valid"}, 32'(if_valid), 32'h0);
    checkOutput({tag, ".rst_instr"}, if_instr, NOP);
    checkOutput({tag, ".rst_fetch_cnt"}, fetch_cnt, 32'h0);
    checkOutput({tag, ".rst_redirect_cnt"}, redirect_cnt, 32'h0);
    modelReset();
    compareAll(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] br;
    int frozen;

    modelReset();
    repeat (2) @(negedge clk);
    compareAll("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) applyStimulus("seq", 0, 0, 32'h0, 0, 0);
    checkOutput("seq_pc_0x10", 32'(imem_addr), 32'h10);
    checkOutput("seq_cur_pc_lag", 32'(Cur_PC), 32'hC);

    applyStimulus("redir_stall", 1, 1, 32'h40, 0, 0);
    checkOutput("redir_stall_pc", 32'(imem_addr), 32'h40);
    checkOutput("redir_stall_instr", if_instr, 32'h0000_0013);
    checkOutput("redir_stall_valid", 32'(if_valid), 32'h0);

    applyStimulus("to_top", 0, 1, 32'h1FC, 0, 0);
    applyStimulus("wrap", 0, 0, 32'h0, 0, 0);
    checkOutput("wrap_pc", 32'(imem_addr), 32'h0);
    checkOutput("wrap_no_err", 32'(target_err), 32'h0);

    applyStimulus("bad_target", 0, 1, 32'h1002, 0, 0);
    checkOutput("bad_target_pc", 32'(imem_addr), 32'h0);
    checkOutput("bad_target_err", 32'(target_err), 32'h1);
    applyStimulus("clean_after_bad", 0, 1, 32'h80, 0, 0);
    checkOutput("err_sticky", 32'(target_err), 32'h1);

    applyStimulus("pre_halt", 0, 0, 32'h0, 0, 0);
    applyStimulus("halt_req", 0, 0, 32'h0, 1, 0);
    frozen = m_pc;
    for (int i = 0; i < DRAIN; i++) begin
      applyStimulus("drain", 0, 0, 32'h0, 0, 0);
      checkOutput("drain_bubble", 32'(if_valid), 32'h0);
      checkOutput("drain_halted", 32'(halted), (i == DRAIN - 1) ? 32'h1 : 32'h0);
    end
    applyStimulus("halted_idle", 0, 0, 32'h0, 1, 0);
    checkOutput("halted_pc_frozen", 32'(imem_addr), 32'(frozen));
    applyStimulus("resume", 0, 0, 32'h0, 0, 1);
    applyStimulus("after_resume", 0, 0, 32'h0, 0, 0);
    checkOutput("resume_cur_pc", 32'(Cur_PC), 32'(frozen));
    checkOutput("resume_valid", 32'(if_valid), 32'h1);

    asyncReset("stats_reset");
    for (int i = 0; i < 10; i++) applyStimulus("stats_fetch", 0, 0, 32'h0, 0, 0);
    applyStimulus("stats_redir", 0, 1, 32'h20, 0, 0);
    applyStimulus("stats_redir", 1, 1, 32'h30, 0, 0);
`ifdef PC_FETCH_STATS_EN
    checkOutput("stats_fetch_cnt", fetch_cnt, 32'd10);
    checkOutput("stats_redirect_cnt", redirect_cnt, 32'd2);
`else
    checkOutput("stats_fetch_cnt_tied", fetch_cnt, 32'd0);
    checkOutput("stats_redirect_cnt_tied", redirect_cnt, 32'd0);
`endif
    applyStimulus("pre_mid_reset", 0, 0, 32'h0, 0, 0);
    asyncReset("mid_reset");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8) br = {$urandom_range(0, PC_SPAN / 4 - 1), 2'b00};
      else br = $urandom;
      applyStimulus("rand",
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 15,
                    br,
                    $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
